// File: rtl/multi_xfer_seq_pkg.sv
// Shared definitions for the multi-register transfer sequencer.
// Holds the ALU operand-2 select codes, the operation encodings and the FSM
// state encodings. It also holds the mapping from a register-list bit
// position to an architectural register index.
package multi_xfer_seq_pkg;

  // ALU operand-2 mux select codes
  localparam logic [2:0] S2_REG           = 3'd0;
  localparam logic [2:0] S2_IMM           = 3'd1;
  localparam logic [2:0] S2_SHIFT         = 3'd2;
  localparam logic [2:0] S2_FOUR          = 3'd3;
  localparam logic [2:0] S2_BIT_COUNT     = 3'd4;
  localparam logic [2:0] S2_NOT_BIT_COUNT = 3'd5;

  typedef enum logic [1:0] {
    OP_LDM  = 2'd0,
    OP_STM  = 2'd1,
    OP_PUSH = 2'd2,
    OP_POP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_XFER = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // List bit 8 is LR for PUSH and PC for POP; LDM/STM keep the plain index.
  function automatic logic [3:0] bit_to_reg(input logic [7:0] pos, input op_e op);
    logic [3:0] idx;
    if (pos == 8'd8) begin
      case (op)
        OP_PUSH: idx = 4'd14;
        OP_POP:  idx = 4'd15;
        default: idx = 4'd8;
      endcase
    end else begin
      idx = pos[3:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/multi_xfer_seq_popcount_lsb.sv
// popcount_lsb: combinational population count and lowest-set-bit position.
// Ports:
//   list_i  : bit vector to examine
//   count_o : number of set bits
//   lsb_o   : position of the lowest set bit (0 when the vector is empty)
module popcount_lsb #(
  parameter int W     = 9,
  parameter int CNT_W = 4,
  parameter int IDX_W = 4
) (
  input  logic [W-1:0]     list_i,
  output logic [CNT_W-1:0] count_o,
  output logic [IDX_W-1:0] lsb_o
);

  // Count set bits and find the lowest one; scan downward so the last hit wins.
  always_comb begin
    count_o = {CNT_W{1'b0}};
    lsb_o   = {IDX_W{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      if (list_i[i]) begin
        count_o = count_o + {{(CNT_W-1){1'b0}}, 1'b1};
        lsb_o   = IDX_W'(i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/multi_xfer_seq.sv
// multi_xfer_seq: sequencer for LDM/STM/PUSH/POP multi-register transfers.
// Walks IDLE -> ADDR -> XFER (one beat per set list bit) -> WB -> IDLE.
// It drives the ALU operand-2 select and carry-in for the address phase and
// the write-back phase. It also presents one register per beat to memory.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op         : transfer request and operation (sampled in IDLE only)
//   reg_list          : register list, captured on the accepted start
//   mem_ready         : memory accepts/returns the current beat
//   busy              : sequencer not idle
//   alu_src2_choose   : ALU operand-2 select code
//   alu_cin           : ALU carry-in
//   bit_count_number  : 4 x popcount of the captured list
//   xfer_valid/reg/offset : current beat, its register and its byte offset
//   base_we           : write ALU result back to base/SP
//   done              : one-cycle completion pulse (WB cycle)
// BASE_REG is the LDM base register index. An LDM that also loads it keeps
// the loaded value and does not write the base back.
module multi_xfer_seq
  import multi_xfer_seq_pkg::*;
#(
  parameter int         REG_LIST_W = 9,
  parameter logic [3:0] BASE_REG   = 4'd13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [REG_LIST_W-1:0] reg_list,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic [2:0]            alu_src2_choose,
  output logic                  alu_cin,
  output logic [31:0]           bit_count_number,
  output logic                  xfer_valid,
  output logic [3:0]            xfer_reg,
  output logic [5:0]            xfer_offset,
  output logic                  base_we,
  output logic                  done
);

  localparam int CNT_W = $clog2(REG_LIST_W + 1);
  localparam int IDX_W = (REG_LIST_W > 1) ? $clog2(REG_LIST_W) : 1;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [REG_LIST_W-1:0] list_q, list_d;
  logic [31:0]           bcn_q, bcn_d;
  logic [5:0]            off_q, off_d;
  logic                  ldm_sup_q, ldm_sup_d;

  logic [REG_LIST_W-1:0] pc_in_s;
  logic [CNT_W-1:0]      pc_count_s;
  logic [IDX_W-1:0]      pc_lsb_s;
  logic [REG_LIST_W-1:0] clr_mask_s;
  logic [REG_LIST_W-1:0] list_left_s;
  logic                  base_hit_s;

  // In IDLE the counter sizes the incoming list; afterwards it scans what is left.
  assign pc_in_s = (state_q == ST_IDLE) ? reg_list : list_q;

  popcount_lsb #(
    .W     (REG_LIST_W),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_popcount_lsb (
    .list_i  (pc_in_s),
    .count_o (pc_count_s),
    .lsb_o   (pc_lsb_s)
  );

  assign clr_mask_s  = {{(REG_LIST_W-1){1'b0}}, 1'b1} << pc_lsb_s;
  assign list_left_s = list_q & ~clr_mask_s;

  // Does the incoming list contain the LDM base register?
  always_comb begin
    base_hit_s = 1'b0;
    for (int i = 0; i < REG_LIST_W; i++) begin
      if (reg_list[i] && (bit_to_reg(8'(i), OP_LDM) == BASE_REG)) begin
        base_hit_s = 1'b1;
      end else begin
        base_hit_s = base_hit_s;
      end
    end
  end

  // State and captured-transfer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LDM;
      list_q    <= {REG_LIST_W{1'b0}};
      bcn_q     <= 32'd0;
      off_q     <= 6'd0;
      ldm_sup_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      list_q    <= list_d;
      bcn_q     <= bcn_d;
      off_q     <= off_d;
      ldm_sup_q <= ldm_sup_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    list_d    = list_q;
    bcn_d     = bcn_q;
    off_d     = off_q;
    ldm_sup_d = ldm_sup_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ADDR;
          op_d      = op_e'(op);
          list_d    = reg_list;
          bcn_d     = {{(32-CNT_W-2){1'b0}}, pc_count_s, 2'b00};
          off_d     = 6'd0;
          ldm_sup_d = (op_e'(op) == OP_LDM) && base_hit_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (list_q != {REG_LIST_W{1'b0}}) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_XFER: begin
        if (mem_ready) begin
          list_d = list_left_s;
          off_d  = off_q + 6'd4;
          if (list_left_s == {REG_LIST_W{1'b0}}) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    alu_src2_choose = S2_REG;
    alu_cin         = 1'b0;
    xfer_valid      = 1'b0;
    xfer_reg        = 4'd0;
    base_we         = 1'b0;
    done            = 1'b0;
    case (state_q)
      ST_ADDR: begin
        if (op_q == OP_PUSH) begin
          alu_src2_choose = S2_NOT_BIT_COUNT;
          alu_cin         = 1'b1;
        end else begin
          alu_src2_choose = S2_REG;
          alu_cin         = 1'b0;
        end
      end
      ST_XFER: begin
        xfer_valid = 1'b1;
        xfer_reg   = bit_to_reg(8'(pc_lsb_s), op_q);
      end
      ST_WB: begin
        done = 1'b1;
        if (op_q == OP_PUSH) begin
          // Keep the ALU producing SP - 4n so the ADDR result is written back.
          alu_src2_choose = S2_NOT_BIT_COUNT;
          alu_cin         = 1'b1;
          base_we         = 1'b1;
        end else begin
          alu_src2_choose = S2_BIT_COUNT;
          alu_cin         = 1'b0;
          base_we         = ~ldm_sup_q;
        end
      end
      default: begin
        alu_src2_choose = S2_REG;
      end
    endcase
  end

  assign busy             = (state_q != ST_IDLE);
  assign bit_count_number = bcn_q;
  assign xfer_offset      = off_q;

endmodule

// File: tb/tb_multi_xfer_seq.sv
// Scoreboard bench for multi_xfer_seq. Each test pushes its hand-computed
// ADDR / beat / WB events into a queue. A negedge monitor pops an event and
// compares it whenever the DUT presents one.
module tb_multi_xfer_seq;

  localparam logic [1:0] K_ADDR = 2'd0;
  localparam logic [1:0] K_BEAT = 2'd1;
  localparam logic [1:0] K_WB   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  sel;
    logic        cin;
    logic        we;
    logic [31:0] bcn;
    logic [3:0]  rg;
    logic [5:0]  off;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [8:0]  reg_list = 9'd0;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic [2:0]  alu_src2_choose;
  logic        alu_cin;
  logic [31:0] bit_count_number;
  logic        xfer_valid;
  logic [3:0]  xfer_reg;
  logic [5:0]  xfer_offset;
  logic        base_we;
  logic        done;

  int checks = 0;
  int failures = 0;
  ev_t exp_q[$];

  multi_xfer_seq #(.REG_LIST_W(9), .BASE_REG(4'd3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .op               (op),
    .reg_list         (reg_list),
    .mem_ready        (mem_ready),
    .busy             (busy),
    .alu_src2_choose  (alu_src2_choose),
    .alu_cin          (alu_cin),
    .bit_count_number (bit_count_number),
    .xfer_valid       (xfer_valid),
    .xfer_reg         (xfer_reg),
    .xfer_offset      (xfer_offset),
    .base_we          (base_we),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(input logic [1:0] k, input logic [2:0] s, input logic c,
                             input logic w, input logic [31:0] b, input logic [3:0] r,
                             input logic [5:0] o);
    ev_t e;
    e.kind = k; e.sel = s; e.cin = c; e.we = w; e.bcn = b; e.rg = r; e.off = o;
    return e;
  endfunction

  task automatic push_addr(input logic [2:0] s, input logic c, input logic [31:0] b);
    exp_q.push_back(mk(K_ADDR, s, c, 1'b0, b, 4'd0, 6'd0));
  endtask

  task automatic push_beat(input logic [3:0] r, input logic [5:0] o);
    exp_q.push_back(mk(K_BEAT, 3'd0, 1'b0, 1'b0, 32'd0, r, o));
  endtask

  task automatic push_wb(input logic [2:0] s, input logic c, input logic w, input logic [31:0] b);
    exp_q.push_back(mk(K_WB, s, c, w, b, 4'd0, 6'd0));
  endtask

  // Monitor: classify what the DUT presents and compare against the queue head.
  always @(negedge clk) begin
    ev_t act;
    if (rst_n && busy) begin
      if (done) begin
        act = mk(K_WB, alu_src2_choose, alu_cin, base_we, bit_count_number, 4'd0, 6'd0);
      end else if (xfer_valid) begin
        act = mk(K_BEAT, 3'd0, 1'b0, 1'b0, 32'd0, xfer_reg, xfer_offset);
      end else begin
        act = mk(K_ADDR, alu_src2_choose, alu_cin, base_we, bit_count_number, 4'd0, 6'd0);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got %h, required nothing pending", act);
      end else if (act != exp_q[0]) begin
        failures++;
        $display("FAIL event: got %h, required %h", act, exp_q[0]);
        void'(exp_q.pop_front());
      end else if (!(xfer_valid && !mem_ready)) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_zero_outputs(input string name);
    logic [50:0] v;
    v = {busy, alu_src2_choose, alu_cin, bit_count_number, xfer_valid, xfer_reg,
         xfer_offset, base_we, done};
    checks++;
    if (v != 51'd0) begin
      failures++;
      $display("FAIL %s: outputs %h, required all zero", name, v);
    end
  endtask

  // Issue one transfer and count edges until done. Optional stall window,
  // start-while-busy injection, and mid-transfer reset.
  task automatic run(input string name, input logic [1:0] o, input logic [8:0] l,
                     input int exp_lat, input int stall_at, input int stall_len,
                     input int busy_at, input int rst_at);
    int cnt;
    int got;
    cnt = 0;
    got = 0;
    op = o;
    reg_list = l;
    mem_ready = 1'b1;
    start = 1'b1;
    while (cnt < 40 && got == 0) begin
      @(posedge clk);
      #1;
      cnt++;
      start = 1'b0;
      if (cnt == stall_at) mem_ready = 1'b0;
      if (cnt == stall_at + stall_len) mem_ready = 1'b1;
      if (cnt == busy_at) begin
        start = 1'b1;
        op = 2'd3;
        reg_list = 9'h1FF;
      end
      if (cnt == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs({name, "_reset"});
        exp_q.delete();
        got = 2;
      end else if (done) begin
        got = 1;
      end
    end
    if (got == 2) begin
      @(posedge clk);
      #3;
      check_zero_outputs({name, "_in_reset"});
      rst_n = 1'b1;
      mem_ready = 1'b1;
    end else begin
      checks++;
      if (got == 0) begin
        failures++;
        $display("FAIL %s_timeout: no done after %0d cycles", name, cnt);
      end else if (cnt != exp_lat) begin
        failures++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, cnt, exp_lat);
      end
      start = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_idle_after: busy %b, required 0", name, busy);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // PUSH 0x103: SP - 12, beats R0, R1, LR
    push_addr(3'd5, 1'b1, 32'd12);
    push_beat(4'd0, 6'd0);
    push_beat(4'd1, 6'd4);
    push_beat(4'd14, 6'd8);
    push_wb(3'd5, 1'b1, 1'b1, 32'd12);
    run("push", 2'd2, 9'h103, 5, -1, 0, -1, -1);

    // POP 0x180: R7 then PC
    push_addr(3'd0, 1'b0, 32'd8);
    push_beat(4'd7, 6'd0);
    push_beat(4'd15, 6'd4);
    push_wb(3'd4, 1'b0, 1'b1, 32'd8);
    run("pop", 2'd3, 9'h180, 4, -1, 0, -1, -1);

    // LDM 0x0F with a 3-cycle stall on beat 2; base R3 loaded so no write-back
    push_addr(3'd0, 1'b0, 32'd16);
    push_beat(4'd0, 6'd0);
    push_beat(4'd1, 6'd4);
    push_beat(4'd2, 6'd8);
    push_beat(4'd3, 6'd12);
    push_wb(3'd4, 1'b0, 1'b0, 32'd16);
    run("ldm_stall", 2'd0, 9'h00F, 9, 3, 3, -1, -1);

    // LDM 0x05: base not in list, write-back enabled
    push_addr(3'd0, 1'b0, 32'd8);
    push_beat(4'd0, 6'd0);
    push_beat(4'd2, 6'd4);
    push_wb(3'd4, 1'b0, 1'b1, 32'd8);
    run("ldm_wb", 2'd0, 9'h005, 4, -1, 0, -1, -1);

    // Empty STM: ADDR, WB, no beats
    push_addr(3'd0, 1'b0, 32'd0);
    push_wb(3'd4, 1'b0, 1'b1, 32'd0);
    run("stm_empty", 2'd1, 9'h000, 2, -1, 0, -1, -1);

    // STM 0x0A with a second start injected while transferring
    push_addr(3'd0, 1'b0, 32'd8);
    push_beat(4'd1, 6'd0);
    push_beat(4'd3, 6'd4);
    push_wb(3'd4, 1'b0, 1'b1, 32'd8);
    run("start_busy", 2'd1, 9'h00A, 4, -1, 0, 2, -1);

    // Reset while beat 2 is stalled, then a normal PUSH
    push_addr(3'd0, 1'b0, 32'd16);
    push_beat(4'd0, 6'd0);
    push_beat(4'd1, 6'd4);
    push_beat(4'd2, 6'd8);
    push_beat(4'd3, 6'd12);
    push_wb(3'd4, 1'b0, 1'b0, 32'd16);
    run("mid_reset", 2'd0, 9'h00F, 0, 3, 10, -1, 3);

    push_addr(3'd5, 1'b1, 32'd8);
    push_beat(4'd0, 6'd0);
    push_beat(4'd2, 6'd4);
    push_wb(3'd5, 1'b1, 1'b1, 32'd8);
    run("after_reset", 2'd2, 9'h005, 4, -1, 0, -1, -1);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d events left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
